jammer_scan_ctrl: RTL and testbench

JAMMER_SCAN_CTRL -- requirements
Module: jammer_scan_ctrl

---
 rtl/jammer_scan_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_jammer_scan_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/jammer_scan_ctrl.sv
// jammer_scan_ctrl: scans a small jammer table and reports which jammer
// circles (center xJ/yJ, radius rJ) contain the captured point P.
// One shared signed multiplier squares dx, dy and rJ on successive cycles.
// Optional build macro: SCAN_EARLY_EXIT_EN -- stop the scan at the first
// in-range entry (one-hot in_mask, hit_count = 1).
module jammer_scan_ctrl #(
    parameter int N = 8,
    parameter int M = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [$clog2(M)-1:0]  wr_idx,
    input  logic signed [N-1:0]   wr_xJ,
    input  logic signed [N-1:0]   wr_yJ,
    input  logic [N:0]            wr_rJ,
    input  logic                  start,
    input  logic signed [N+1:0]   xP,
    input  logic signed [N+1:0]   yP,
    output logic                  busy,
    output logic                  done,
    output logic [M-1:0]          in_mask,
    output logic [$clog2(M):0]    hit_count
);

    localparam int IW = $clog2(M);
    localparam int DW = N + 3;      // dx, dy
    localparam int SW = 2 * N + 6;  // squares
    localparam int AW = 2 * N + 7;  // dx^2 + dy^2
    localparam int RW = 2 * N + 2;  // rJ^2

    typedef enum logic [2:0] {S_IDLE, S_SQX, S_SQY, S_SQR, S_CMP, S_DONE} state_t;

    state_t                state_q, state_d;
    logic signed [N-1:0]   xj_q [M];
    logic signed [N-1:0]   xj_d [M];
    logic signed [N-1:0]   yj_q [M];
    logic signed [N-1:0]   yj_d [M];
    logic [N:0]            rj_q [M];
    logic [N:0]            rj_d [M];
    logic signed [N+1:0]   px_q, px_d, py_q, py_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic signed [AW-1:0]  acc_q, acc_d;
    logic [RW-1:0]         r2_q, r2_d;
    logic [M-1:0]          work_q, work_d, mask_q, mask_d;
    logic [IW:0]           cnt_q, cnt_d;

    logic signed [DW-1:0]  dx, dy, rop, mul_a;
    logic signed [SW-1:0]  prod;
    logic signed [AW-1:0]  r2_ext;
    logic                  hit, last;

    function automatic logic [IW:0] popcnt(input logic [M-1:0] v);
        logic [IW:0] c;
        c = '0;
        for (int k = 0; k < M; k++) c = c + (IW+1)'(v[k]);
        return c;
    endfunction

    // Datapath: operand select for the single shared squarer, and the compare.
    always_comb begin
        dx    = DW'(px_q) - DW'(xj_q[idx_q]);
        dy    = DW'(py_q) - DW'(yj_q[idx_q]);
        rop   = DW'(rj_q[idx_q]);           // radius is unsigned: zero-extend
        mul_a = '0;
        case (state_q)
            S_SQX:   mul_a = dx;
            S_SQY:   mul_a = dy;
            S_SQR:   mul_a = rop;
            default: mul_a = '0;
        endcase
        prod   = SW'(mul_a) * SW'(mul_a);
        r2_ext = AW'({1'b0, r2_q});
        hit    = (acc_q <= r2_ext);         // boundary counts as in range
        last   = (idx_q == IW'(M - 1));
    end

    // Next-state, table write and result logic.
    always_comb begin
        state_d = state_q;
        xj_d    = xj_q;
        yj_d    = yj_q;
        rj_d    = rj_q;
        px_d    = px_q;
        py_d    = py_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        r2_d    = r2_q;
        work_d  = work_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                // write and start on the same edge: scan sees the new entry
                if (wr_en) begin
                    xj_d[wr_idx] = wr_xJ;
                    yj_d[wr_idx] = wr_yJ;
                    rj_d[wr_idx] = wr_rJ;
                end
                if (start) begin
                    px_d    = xP;
                    py_d    = yP;
                    idx_d   = '0;
                    work_d  = '0;
                    state_d = S_SQX;
                end
            end
            S_SQX: begin
                acc_d   = AW'(prod);
                state_d = S_SQY;
            end
            S_SQY: begin
                acc_d   = acc_q + AW'(prod);
                state_d = S_SQR;
            end
            S_SQR: begin
                r2_d    = prod[RW-1:0];
                state_d = S_CMP;
            end
            S_CMP: begin
                work_d[idx_q] = hit;
`ifdef SCAN_EARLY_EXIT_EN
                if (hit) begin
                    mask_d        = '0;
                    mask_d[idx_q] = 1'b1;
                    cnt_d         = (IW+1)'(1);
                    state_d       = S_DONE;
                end else if (last) begin
                    mask_d  = work_d;       // no hit anywhere: all zero
                    cnt_d   = popcnt(work_d);
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_SQX;
                end
`else
                if (last) begin
                    mask_d  = work_d;
                    cnt_d   = popcnt(work_d);
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_SQX;
                end
`endif
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and table registers; reset abandons any scan and clears the table.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            for (int k = 0; k < M; k++) begin
                xj_q[k] <= '0;
                yj_q[k] <= '0;
                rj_q[k] <= '0;
            end
            px_q   <= '0;
            py_q   <= '0;
            idx_q  <= '0;
            acc_q  <= '0;
            r2_q   <= '0;
            work_q <= '0;
            mask_q <= '0;
            cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            xj_q    <= xj_d;
            yj_q    <= yj_d;
            rj_q    <= rj_d;
            px_q    <= px_d;
            py_q    <= py_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            r2_q    <= r2_d;
            work_q  <= work_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign in_mask   = mask_q;
    assign hit_count = cnt_q;

endmodule

// File: tb/tb_jammer_scan_ctrl.sv
// Self-checking bench for jammer_scan_ctrl (N=8, M=4), scoreboard style.
// Honors SCAN_EARLY_EXIT_EN when the same macro is defined for the build.
module tb_jammer_scan_ctrl;

    localparam int N = 8;
    localparam int M = 4;
`ifdef SCAN_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr_en = 1'b0;
    logic [1:0]        wr_idx = '0;
    logic signed [7:0] wr_xJ = '0;
    logic signed [7:0] wr_yJ = '0;
    logic [8:0]        wr_rJ = '0;
    logic              start = 1'b0;
    logic signed [9:0] xP = '0;
    logic signed [9:0] yP = '0;
    logic              busy, done;
    logic [3:0]        in_mask;
    logic [2:0]        hit_count;

    jammer_scan_ctrl #(.N(N), .M(M)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx),
        .wr_xJ(wr_xJ), .wr_yJ(wr_yJ), .wr_rJ(wr_rJ), .start(start),
        .xP(xP), .yP(yP), .busy(busy), .done(done),
        .in_mask(in_mask), .hit_count(hit_count)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt++;

    typedef struct {int mask; int cnt; int lat; int s_edge;} exp_t;
    exp_t sb[$];
    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: done=1 at edge %0d, expected 0", edge_cnt);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("in_mask", 32'(in_mask), e.mask);
                chk("hit_count", 32'(hit_count), e.cnt);
                chk("done_latency", edge_cnt + 1 - e.s_edge, e.lat);
            end
        end
    end

    task automatic wait_done();
        int i;
        i = 0;
        while (!done && i < 200) begin
            @(negedge clk);
            i++;
        end
        chk("done_timeout", 32'(done), 1);
    endtask

    task automatic wr(input int idx, input int xj, input int yj, input int rj);
        @(negedge clk);
        wr_en  = 1'b1;
        wr_idx = 2'(idx);
        wr_xJ  = 8'(xj);
        wr_yJ  = 8'(yj);
        wr_rJ  = 9'(rj);
        @(negedge clk);
        wr_en  = 1'b0;
    endtask

    // Issue a start (optionally with a write on the same edge) and queue the
    // expected outcome; the start edge is the next rising edge.
    task automatic scan(input bit w, input int idx, input int xj, input int yj, input int rj,
                        input int xp, input int yp, input int em, input int ec, input int el,
                        input bit expect_done, input bit do_wait);
        exp_t e;
        @(negedge clk);
        wr_en  = w;
        wr_idx = 2'(idx);
        wr_xJ  = 8'(xj);
        wr_yJ  = 8'(yj);
        wr_rJ  = 9'(rj);
        xP     = 10'(xp);
        yP     = 10'(yp);
        start  = 1'b1;
        if (expect_done) begin
            e.mask = em; e.cnt = ec; e.lat = el; e.s_edge = edge_cnt + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        wr_en = 1'b0;
        if (do_wait) wait_done();
    endtask

    initial begin
        #1;
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_mask", 32'(in_mask), 0);
        chk("reset_cnt", 32'(hit_count), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // entry3=(0,0,5), P=(3,4): 25 == 25, in range; other entries r=0
        scan(1, 3, 0, 0, 5, 3, 4, 8, 1, 17, 1, 1);
        // P=(3,5): 34 > 25
        scan(0, 0, 0, 0, 0, 3, 5, 0, 0, 17, 1, 1);
        // P=(0,0): zero-radius entries at origin hit on equality 0 <= 0
        scan(0, 0, 0, 0, 0, 0, 0, EE ? 1 : 15, EE ? 1 : 4, EE ? 5 : 17, 1, 1);
        // entry0=(-32,108,215), P=(151,-276): 180945 > 46225
        scan(1, 0, -32, 108, 215, 151, -276, 0, 0, 17, 1, 1);
        // entry1=(109,-99,183), P=(-231,5): 126416 > 33489
        scan(1, 1, 109, -99, 183, -231, 5, 0, 0, 17, 1, 1);
        // entry2=(-16,-111,236); P=(-72,-102): e0 45700, e1 32770, e2 3217 in
        wr(2, -16, -111, 236);
        scan(0, 0, 0, 0, 0, -72, -102, EE ? 1 : 7, EE ? 1 : 3, EE ? 5 : 17, 1, 1);
        // back-to-back start in the cycle after done, P=(3,4): all in
        scan(0, 0, 0, 0, 0, 3, 4, EE ? 1 : 15, EE ? 1 : 4, EE ? 5 : 17, 1, 1);
        // only entries 1 and 3 in range
        wr(0, -128, -128, 1);
        wr(2, 127, 127, 1);
        scan(0, 0, 0, 0, 0, 3, 4, EE ? 2 : 10, EE ? 1 : 2, EE ? 9 : 17, 1, 1);
        // extremes: dx=-639, dy=639 -> 816642 > 261121
        scan(1, 0, 127, -128, 511, -512, 511, 0, 0, 17, 1, 1);
        // P=(-200,200): e0 214513 <= 261121
        scan(0, 0, 0, 0, 0, -200, 200, 1, 1, EE ? 5 : 17, 1, 1);

        // start and write pulsed mid-scan must be ignored
        scan(0, 0, 0, 0, 0, 3, 4, EE ? 1 : 11, EE ? 1 : 3, EE ? 5 : 17, 1, 0);
        @(negedge clk);
        chk("busy_mid_scan", 32'(busy), 1);
        wr_en = 1'b1; wr_idx = 2'd3; wr_xJ = 8'sd100; wr_yJ = 8'sd100; wr_rJ = 9'd0;
        xP = -10'sd200; yP = 10'sd200; start = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; start = 1'b0;
        wait_done();
        // same scan again: entry3 must still be (0,0,5)
        scan(0, 0, 0, 0, 0, 3, 4, EE ? 1 : 11, EE ? 1 : 3, EE ? 5 : 17, 1, 1);
        repeat (3) @(negedge clk);
        chk("mask_hold", 32'(in_mask), EE ? 1 : 11);
        chk("cnt_hold", 32'(hit_count), EE ? 1 : 3);
        chk("idle_busy", 32'(busy), 0);

        // reset mid-scan (no entry in range, so the scan would run to the end)
        scan(0, 0, 0, 0, 0, -512, -512, 0, 0, 0, 0, 0);
        repeat (6) @(posedge clk);
        chk("busy_before_rst", 32'(busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_mask", 32'(in_mask), 0);
        chk("rst_cnt", 32'(hit_count), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        // table cleared: every entry is (0,0,0), P=(0,0) hits all
        scan(0, 0, 0, 0, 0, 0, 0, EE ? 1 : 15, EE ? 1 : 4, EE ? 5 : 17, 1, 1);

        repeat (5) @(negedge clk);
        chk("pending_expectations", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
